mimo_sym_mapper: RTL and testbench
==================================

# mimo_sym_mapper

Transmit-side 64-QAM symbol mapper for the 8-dimension real-valued MIMO chain. It packs an incoming byte stream into 24-bit vectors and maps each 3-bit group onto a Gray-coded PAM-8 level. Each vector produces one 8-symbol real vector `s1..s8`, 12-bit signed, in the same number format the layered K-best detector consumes. It sits between the bit source and the channel/testbench model. Input and output both use valid/ready handshakes, with one pending-vector buffer so the input can keep streaming while the output is stalled.

## Interface
- `LVL_SHIFT`, default 0: left shift applied to every PAM level; legal range 0..7, since 7<<7 = 896 fits in 12-bit signed.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the source presents a byte.
- `in_ready` output 1: the mapper can accept a byte.
- `in_data` input 8: byte payload; first byte of a vector = bits[7:0], second = [15:8], third = [23:16].
- `in_last` input 1: marks the final byte of a frame; qualified by the input transfer.
- `out_valid` output 1: the symbol vector is valid.
- `out_ready` input 1: the downstream sink accepts the vector.
- `out_sym` output 96: packed symbols, `s1` = [11:0] … `s8` = [95:84], each 12-bit signed.
- `out_last` output 1: this vector closes the frame.
- `out_idx` output 8: vector index within the frame, wrapping 255→0.

## Operation
- An input transfer is `in_valid && in_ready`; an output transfer is `out_valid && out_ready`.
- Assembly FSM states:
  - `B0`, `B1`, `B2`: number of bytes held so far.
  - `FULL`: a complete vector is waiting for the output register.
- `in_ready` = (state != `FULL`); it is combinational from the state only and does not depend on `out_ready`.
- A vector completes when a byte is accepted in `B2`, or when a byte is accepted with `in_last=1` in any state.
  - On an `in_last` completion, the unfilled upper bits of the 24-bit word are zero.
- Output register slot is free = `!out_valid || out_ready`.
  - On completion with the slot free: load the output register; the FSM goes to `B0`.
  - On completion with the slot not free: the FSM goes to `FULL`.
  - In `FULL` with the slot free: load the output register; the FSM goes to `B0`.
- Symbol k (1..8) takes word bits [3k-1:3k-3]. Gray map: 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7. The result is sign-extended to 12 bits, then shifted left by `LVL_SHIFT`.
- `out_last` is loaded with the completing byte's `in_last`.
- `out_idx` is loaded from the frame counter, which increments on every load and clears to 0 after loading a vector with `last=1`.
- While `out_valid=1 && out_ready=0`, `out_sym`, `out_last` and `out_idx` hold stable.
- On an output transfer with no new load, `out_valid` falls next edge; `out_sym` keeps its last value.

## Timing
- Reset values, applied immediately while `rstn` is low:
  - state `B0`, so `in_ready` = 1;
  - `out_valid` = 0, `out_sym` = 0, `out_last` = 0, `out_idx` = 0;
  - frame counter 0, assembly word 0.
- Reset mid-vector or mid-frame discards any partial bytes, the pending vector and the output vector; no output appears for them.
- Latency: `out_valid` rises at the first edge after the completing byte is accepted, provided the slot is free.
- Throughput: one vector per 3 cycles. Back-to-back output transfers sustain full rate with `out_ready` tied high.
- Simultaneous events:
  - A completing byte arriving in the same cycle as an output transfer loads the new vector with no bubble.
  - `FULL` + `out_ready` = 1 loads the pending vector and reopens `in_ready` in the same edge.
- No data loss: at most one complete vector is pending plus one in the output register. Further input is blocked via `in_ready` = 0.

## Test plan
- Bytes 0xC8, 0xE4, 0x97 with `LVL_SHIFT`=0 and `out_ready`=1 → one cycle after the third byte:
  - `out_sym` s1..s8 = -7,-5,-3,-1,+1,+3,+5,+7 (s1 = 0xFF9, s8 = 0x007);
  - `out_idx` = 0, `out_last` = 0.
- Same bytes with `LVL_SHIFT`=2 → s1 = -28 (0xFE4), s8 = +28 (0x01C).
- Single byte 0xFF with `in_last`=1 → s1 = +3, s2 = +3, s3 = -3, s4..s8 = -7, `out_last` = 1. The next vector has `out_idx` = 0.
- `out_ready` held 0 while 6 bytes are sent:
  - the first vector holds stable in the output register;
  - the second vector goes `FULL`, and `in_ready` = 0 after byte 6;
  - releasing `out_ready` delivers both vectors in order with nothing dropped.
- 257 complete vectors with no `in_last` → `out_idx` runs 0..255 then 0.
- Assert `rstn` low after 2 bytes of a vector, then send 0xC8, 0xE4, 0x97 → only the -7..+7 vector is emitted, with `out_idx` = 0.

Source files
------------

// File: rtl/mimo_sym_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : mimo_sym_mapper
//  Purpose  : Transmit-side 64-QAM symbol mapper for the 8-dimension
//             real-valued MIMO chain. Packs a byte stream into 24-bit
//             vectors and maps each 3-bit group onto a Gray-coded PAM-8
//             level (12-bit signed, optionally scaled by LVL_SHIFT).
//  Ports    : clk, rstn       - clock, asynchronous active-low reset
//             in_valid/in_ready/in_data/in_last - byte input handshake
//             out_valid/out_ready               - vector output handshake
//             out_sym  [95:0] - s1 = [11:0] ... s8 = [95:84]
//             out_last        - vector closes the frame
//             out_idx  [7:0]  - vector index within the frame
//  Revision : 1.0 - initial release
// ============================================================================
module mimo_sym_mapper #(
    parameter int LVL_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_sym,
    output logic        out_last,
    output logic [7:0]  out_idx
);

    // Assembly state: number of bytes held, or a complete vector parked.
    typedef enum logic [1:0] {
        ST_B0   = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2,
        ST_FULL = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_word;
    logic        r_pend_last;
    logic        r_out_valid;
    logic [95:0] r_out_sym;
    logic        r_out_last;
    logic [7:0]  r_out_idx;
    logic [7:0]  r_frame_cnt;

    logic        w_accept;
    logic        w_slot_free;
    logic        w_complete;
    logic [23:0] w_asm_word;
    logic        w_load;
    logic [23:0] w_load_word;
    logic        w_load_last;
    logic [95:0] w_map_sym;

    // Gray PAM-8: converting the Gray code to a binary index gives a
    // monotone level 2*idx - 7, then sign-extend and scale.
    function automatic logic [11:0] f_map(input logic [2:0] i_g);
        logic [2:0]        v_idx;
        logic signed [4:0] v_lvl;
        logic [11:0]       v_ext;
        v_idx = {i_g[2], i_g[2] ^ i_g[1], i_g[2] ^ i_g[1] ^ i_g[0]};
        v_lvl = $signed({1'b0, v_idx, 1'b0}) - 5'sd7;
        v_ext = {{7{v_lvl[4]}}, v_lvl};
        return v_ext << LVL_SHIFT;
    endfunction

    assign in_ready    = (r_state != ST_FULL);
    assign w_accept    = in_valid && in_ready;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_complete  = w_accept && ((r_state == ST_B2) || in_last);

    // Word as it would look with the current byte inserted; bytes above the
    // current position are forced to zero so an early in_last pads cleanly.
    always_comb begin
        w_asm_word = r_word;
        case (r_state)
            ST_B0:   w_asm_word = {16'h0000, in_data};
            ST_B1:   w_asm_word = {8'h00, in_data, r_word[7:0]};
            default: w_asm_word = {in_data, r_word[15:0]};
        endcase
    end

    // Next-state and output-register load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_word = w_asm_word;
        w_load_last = in_last;
        case (r_state)
            ST_FULL: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_word = r_word;
                    w_load_last = r_pend_last;
                    w_state_nxt = ST_B0;
                end
            end
            default: begin
                if (w_complete) begin
                    if (w_slot_free) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_B0;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end else if (w_accept) begin
                    w_state_nxt = (r_state == ST_B0) ? ST_B1 : ST_B2;
                end
            end
        endcase
    end

    for (genvar k = 0; k < 8; k++) begin : g_sym
        assign w_map_sym[12*k +: 12] = f_map(w_load_word[3*k +: 3]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_word      <= 24'h000000;
            r_pend_last <= 1'b0;
        end else if (w_accept) begin
            // In FULL no byte is accepted, so the parked vector stays in r_word.
            r_word      <= w_asm_word;
            r_pend_last <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_sym   <= 96'h0;
            r_out_last  <= 1'b0;
            r_out_idx   <= 8'h00;
            r_frame_cnt <= 8'h00;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sym   <= w_map_sym;
            r_out_last  <= w_load_last;
            r_out_idx   <= r_frame_cnt;
            r_frame_cnt <= w_load_last ? 8'h00 : r_frame_cnt + 8'h01;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign out_last  = r_out_last;
    assign out_idx   = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_mimo_sym_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mimo_sym_mapper
//  Purpose  : Self-checking scoreboard bench for mimo_sym_mapper. Two
//             instances (LVL_SHIFT 0 and 2) share all inputs; expected
//             vectors are queued as bytes are accepted and popped on every
//             output transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mimo_sym_mapper;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready = 1'b0;
    logic        in_ready_a, out_valid_a, out_last_a;
    logic [95:0] out_sym_a;
    logic [7:0]  out_idx_a;
    logic        in_ready_b, out_valid_b, out_last_b;
    logic [95:0] out_sym_b;
    logic [7:0]  out_idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [95:0] s0;
        logic [95:0] s2;
        logic        last;
        logic [7:0]  idx;
    } exp_t;
    exp_t q[$];

    // Reference model state
    int          m_cnt   = 0;
    logic [23:0] m_word  = '0;
    logic [7:0]  m_frame = '0;
    int          or_mode = 0;   // 0: ready low, 1: ready high, 2: random

    always #5 clk = ~clk;

    mimo_sym_mapper #(.LVL_SHIFT(0)) u_dut_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sym(out_sym_a), .out_last(out_last_a),
        .out_idx(out_idx_a)
    );

    mimo_sym_mapper #(.LVL_SHIFT(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sym(out_sym_b), .out_last(out_last_b),
        .out_idx(out_idx_b)
    );

    task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [95:0] model_sym(input logic [23:0] w, input int sh);
        int lut[8] = '{-7, -5, -1, -3, 7, 5, 1, 3};  // indexed by Gray code
        logic [95:0]       s;
        logic signed [31:0] v;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            v = lut[w[3*k +: 3]] * (1 << sh);
            s[12*k +: 12] = v[11:0];
        end
        return s;
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic last);
        exp_t e;
        m_word[8*m_cnt +: 8] = d;
        if (m_cnt == 2 || last) begin
            e.s0 = model_sym(m_word, 0);
            e.s2 = model_sym(m_word, 2);
            e.last = last;
            e.idx = m_frame;
            q.push_back(e);
            m_frame = last ? 8'h00 : m_frame + 8'h01;
            m_cnt = 0;
            m_word = '0;
        end else begin
            m_cnt++;
        end
    endtask

    // Drives one byte; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int t;
        in_valid = 1'b1; in_data = d; in_last = last;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready_a) begin
                model_accept(d, last);
                @(posedge clk); #1;
                break;
            end
            t++;
            if (t > 200) begin
                chk("in_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic set_ready_mode(input int m);
        or_mode = m;
        @(posedge clk); #2;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk); t++;
        end
        #2;
        chk("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        q.delete();
        m_cnt = 0; m_word = '0; m_frame = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_sym", out_sym_a, 0);
        chk("rst_out_last", out_last_a, 0);
        chk("rst_out_idx", out_idx_a, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Single driver of out_ready, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor and stall-hold checker.
    logic        p_stall = 1'b0;
    logic [95:0] p_sym;
    logic        p_last;
    logic [7:0]  p_idx;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_sym", out_sym_a, p_sym);
                chk("hold_last", out_last_a, p_last);
                chk("hold_idx", out_idx_a, p_idx);
            end
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sym_sh0", out_sym_a, e.s0);
                    chk("sym_sh2", out_sym_b, e.s2);
                    chk("out_last", out_last_a, e.last);
                    chk("out_idx", out_idx_a, e.idx);
                end
            end
            p_stall = out_valid_a && !out_ready;
            p_sym = out_sym_a; p_last = out_last_a; p_idx = out_idx_a;
        end
    end

    initial begin
        logic [95:0] held;
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        #12;
        do_reset();

        // Basic vector, latency and explicit level checks
        set_ready_mode(1);
        send_byte(8'hC8, 0); send_byte(8'hE4, 0); send_byte(8'h97, 0);
        chk("lat_valid", out_valid_a, 1);
        chk("t1_s1", out_sym_a[11:0], 12'hFF9);
        chk("t1_s8", out_sym_a[95:84], 12'h007);
        chk("t1_s3", out_sym_a[35:24], 12'hFFD);
        chk("t2_s1", out_sym_b[11:0], 12'hFE4);
        chk("t2_s8", out_sym_b[95:84], 12'h01C);
        chk("t1_idx", out_idx_a, 0);

        // Short frame: single byte with in_last
        send_byte(8'hFF, 1);
        chk("short_s1", out_sym_a[11:0], 12'h003);
        chk("short_s3", out_sym_a[35:24], 12'hFFD);
        chk("short_s8", out_sym_a[95:84], 12'hFF9);
        chk("short_last", out_last_a, 1);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        chk("after_last_idx", out_idx_a, 0);
        drain();

        // Stall: two vectors with out_ready low
        set_ready_mode(0);
        drain();
        send_byte(8'h01, 0); send_byte(8'h23, 0); send_byte(8'h45, 0);
        held = out_sym_a;
        send_byte(8'h67, 0); send_byte(8'h89, 0); send_byte(8'hAB, 0);
        chk("full_in_ready", in_ready_a, 0);
        chk("full_held_sym", out_sym_a, held);
        chk("full_valid", out_valid_a, 1);
        set_ready_mode(1);
        drain();

        // 257 vectors, index wrap
        do_reset();
        set_ready_mode(1);
        for (int v = 0; v < 257; v++) begin
            send_byte(8'($urandom), 0);
            send_byte(8'($urandom), 0);
            send_byte(8'($urandom), 0);
        end
        chk("wrap_idx", out_idx_a, 0);
        drain();

        // Random backpressure with mixed frame lengths
        set_ready_mode(2);
        for (int v = 0; v < 60; v++) begin
            send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
        end
        set_ready_mode(1);
        drain();

        // Reset mid-vector discards the partial bytes
        send_byte(8'h55, 0); send_byte(8'hAA, 0);
        do_reset();
        set_ready_mode(1);
        send_byte(8'hC8, 0); send_byte(8'hE4, 0); send_byte(8'h97, 0);
        chk("rst_vec_s1", out_sym_a[11:0], 12'hFF9);
        chk("rst_vec_idx", out_idx_a, 0);
        drain();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
